multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Multi-cycle instruction sequencer for the RISC core. It steps each instruction through the IF/ID/EX/MEM/WB phases and issues the per-phase enables: PC write, IR write, register write, and data-memory strobes. Instruction and data memory accesses use a req/ready wait-state handshake. It sits beside the combinational `control_unit`, which supplies datapath selects, and reads the same `instr_type`/`opcode` fields from the IR.

## Interface
- `CNT_W`, 16, width of retired-instruction counter
- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `instr_type`  in  2  IR type field: 00 R, 01 I, 10 J, 11 S
- `opcode`  in  5  IR opcode field
- `alu_zero`  in  1  ALU zero flag, valid in EX
- `imem_ready`  in  1  instruction memory has data this cycle
- `dmem_ready`  in  1  data memory completes access this cycle
- `imem_req`  out  1  instruction fetch request
- `ir_write`  out  1  latch IR
- `pc_write`  out  1  load PC
- `pc_src`  out  2  00 PC+1, 01 branch target, 10 jump target
- `reg_wr`  out  1  register-file write strobe
- `link_wr`  out  1  write PC+1 to link register (JAL)
- `dmem_req`  out  1  data access request
- `dmem_we`  out  1  data write (qualifies `dmem_req`)
- `state`  out  3  current state code
- `illegal`  out  1  sticky illegal-instruction flag
- `instr_done`  out  1  one-cycle pulse on retire
- `instr_count`  out  CNT_W  retired-instruction count

## Operation
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, ERR=5.
- The state register is clocked. All strobes are Mealy-decoded from state and inputs. `state` is the register.
- **IF**
  - `imem_req`=1 while in IF.
  - Stay in IF while `imem_ready`=0.
  - On `imem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=00, then go to ID.
- **ID**
  - Classify the instruction.
  - Legal opcodes: R 0–3, I 0–4, J 0–1, S 0–3. Anything else goes to ERR.
  - J: `pc_write`=1, `pc_src`=10, retire, go to IF.
  - JAL: same as J, plus `reg_wr`=1 and `link_wr`=1.
  - All others go to EX.
- **EX**
  - BEQ: if `alu_zero`, then `pc_write`=1 and `pc_src`=01. Retire, go to IF.
  - LW, SW: go to MEM.
  - Everything else: go to WB.
- **MEM**
  - `dmem_req`=1 while in MEM; `dmem_we`=1 for SW only.
  - Stay in MEM while `dmem_ready`=0.
  - On ready: SW retires and goes to IF; LW goes to WB.
- **WB**
  - `reg_wr`=1, retire, go to IF.
  - CMP writes rd like the other R-type instructions.
- **ERR**
  - Terminal. All strobes are 0 and `illegal`=1.
  - Only reset leaves ERR.
- **Retire**
  - `instr_done`=1 in the retiring cycle.
  - `instr_count` increments on the same edge and wraps modulo 2^CNT_W.
- `pc_src` = 00 whenever `pc_write`=0.

## Timing
- Reset (asynchronous assertion, synchronous release):
  - `state`=IF, `instr_count`=0, `illegal`=0.
  - All strobes are 0 while `reset_n`=0.
  - `imem_req`=1 in the first cycle after release.
- Cycles with zero wait states:
  - J/JAL: 2
  - BEQ: 3
  - SW: 4
  - R, ANDI, ADDI, shifts: 4
  - LW: 5
- Each wait cycle adds 1. A ready asserted in any state other than the one waiting on it is ignored.
- Reset mid-MEM drops `dmem_req` immediately, with no partial write. The instruction does not retire.
- `illegal` rises on the edge leaving ID. `instr_done` is never asserted for an illegal instruction.
- `instr_count` at its maximum plus a retire wraps to 0. No overflow flag.

## Structure
- Package `cpu_pkg` holds:
  - state codes
  - `instr_type` codes
  - opcode constants per type
  - `pc_src` encodings
- Sub-module `instr_classifier` (combinational) takes `instr_type`/`opcode` and produces `is_alu`, `is_load`, `is_store`, `is_branch`, `is_jump`, `is_link`, `is_illegal`. The sequencer instantiates it once.

## Test plan
- **ADD (00/00001), readies tied 1:** states IF, ID, EX, WB. `reg_wr` high only in WB. `instr_count` 0→1.
- **LW (01/00010), `dmem_ready` low 2 cycles:** MEM lasts 3 cycles with `dmem_req`=1 and `dmem_we`=0. WB follows. 7 cycles total.
- **BEQ (01/00100):**
  - `alu_zero`=1: `pc_write` with `pc_src`=01 in EX.
  - `alu_zero`=0: no `pc_write` in EX.
  - Both retire after 3 cycles.
- **JAL (10/00001):** in ID, `pc_write`=1, `pc_src`=10, `reg_wr`=1, `link_wr`=1. Next cycle is IF.
- **Illegal (10/00101):** ID goes to ERR. `illegal`=1 and held. `instr_done` never pulses. Strobes stay 0 for 10+ cycles until `reset_n` pulses.
- **Wrap and reset:**
  - Preload near max via CNT_W=4: 16 retires give `instr_count`=0.
  - Assert `reset_n`=0 mid-SW MEM: `dmem_req` falls in the same cycle, and `state` is IF after release.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// Shared encodings for the multi-cycle sequencer: state codes, IR type/opcode
// fields and PC source selects.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4,
    ST_ERR = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    TYPE_R = 2'b00,
    TYPE_I = 2'b01,
    TYPE_J = 2'b10,
    TYPE_S = 2'b11
  } instr_type_e;

  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10
  } pc_src_e;

  localparam logic [4:0] OP_R_AND  = 5'd0;
  localparam logic [4:0] OP_R_ADD  = 5'd1;
  localparam logic [4:0] OP_R_SUB  = 5'd2;
  localparam logic [4:0] OP_R_CMP  = 5'd3;

  localparam logic [4:0] OP_I_ANDI = 5'd0;
  localparam logic [4:0] OP_I_ADDI = 5'd1;
  localparam logic [4:0] OP_I_LW   = 5'd2;
  localparam logic [4:0] OP_I_SW   = 5'd3;
  localparam logic [4:0] OP_I_BEQ  = 5'd4;

  localparam logic [4:0] OP_J_J    = 5'd0;
  localparam logic [4:0] OP_J_JAL  = 5'd1;

  localparam logic [4:0] OP_S_SLL  = 5'd0;
  localparam logic [4:0] OP_S_SRL  = 5'd1;
  localparam logic [4:0] OP_S_SRA  = 5'd2;
  localparam logic [4:0] OP_S_ROL  = 5'd3;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Sequencer-to-datapath bundle: IR fields, memory handshakes and phase strobes.
interface multicycle_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       instr_type;
  logic [4:0]       opcode;
  logic             alu_zero;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             reg_wr;
  logic             link_wr;
  logic             dmem_req;
  logic             dmem_we;
  logic [2:0]       state;
  logic             illegal;
  logic             instr_done;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  instr_type, opcode, alu_zero, imem_ready, dmem_ready,
    output imem_req, ir_write, pc_write, pc_src, reg_wr, link_wr,
           dmem_req, dmem_we, state, illegal, instr_done, instr_count
  );

  modport slave (
    output instr_type, opcode, alu_zero, imem_ready, dmem_ready,
    input  imem_req, ir_write, pc_write, pc_src, reg_wr, link_wr,
           dmem_req, dmem_we, state, illegal, instr_done, instr_count
  );
endinterface

// File: rtl/instr_classifier.sv
// Decodes the IR type/opcode pair into the instruction classes the sequencer
// branches on; any encoding outside the legal opcode ranges is flagged illegal.
module instr_classifier
  import cpu_pkg::*;
(
  input  logic [1:0] instr_type,
  input  logic [4:0] opcode,
  output logic       is_alu,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jump,
  output logic       is_link,
  output logic       is_illegal
);

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    is_alu     = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    is_link    = 1'b0;
    is_illegal = 1'b0;
    case (instr_type)
      TYPE_R: begin
        if (opcode <= OP_R_CMP) is_alu = 1'b1;
        else                    is_illegal = 1'b1;
      end
      TYPE_I: begin
        case (opcode)
          OP_I_ANDI, OP_I_ADDI: is_alu    = 1'b1;
          OP_I_LW:              is_load   = 1'b1;
          OP_I_SW:              is_store  = 1'b1;
          OP_I_BEQ:             is_branch = 1'b1;
          default:              is_illegal = 1'b1;
        endcase
      end
      TYPE_J: begin
        case (opcode)
          OP_J_J:   is_jump = 1'b1;
          OP_J_JAL: begin
            is_jump = 1'b1;
            is_link = 1'b1;
          end
          default:  is_illegal = 1'b1;
        endcase
      end
      TYPE_S: begin
        if (opcode <= OP_S_ROL) is_alu = 1'b1;
        else                    is_illegal = 1'b1;
      end
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer: registered phase state, Mealy-decoded
// strobes, sticky illegal flag and a wrapping retired-instruction counter.
module multicycle_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  multicycle_sequencer_if.master bus
);

  state_e           r_state;
  state_e           w_next;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;

  logic    w_is_alu, w_is_load, w_is_store, w_is_branch;
  logic    w_is_jump, w_is_link, w_is_illegal;
  logic    w_imem_req, w_ir_write, w_pc_write, w_reg_wr, w_link_wr;
  logic    w_dmem_req, w_dmem_we, w_retire;
  pc_src_e w_pc_src;

  instr_classifier u_classifier (
    .instr_type (bus.instr_type),
    .opcode     (bus.opcode),
    .is_alu     (w_is_alu),
    .is_load    (w_is_load),
    .is_store   (w_is_store),
    .is_branch  (w_is_branch),
    .is_jump    (w_is_jump),
    .is_link    (w_is_link),
    .is_illegal (w_is_illegal)
  );

  always_comb begin
    w_next     = r_state;
    w_imem_req = 1'b0;
    w_ir_write = 1'b0;
    w_pc_write = 1'b0;
    w_pc_src   = PC_SRC_SEQ;
    w_reg_wr   = 1'b0;
    w_link_wr  = 1'b0;
    w_dmem_req = 1'b0;
    w_dmem_we  = 1'b0;
    w_retire   = 1'b0;
    case (r_state)
      ST_IF: begin
        w_imem_req = 1'b1;
        if (bus.imem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = ST_ID;
        end
      end
      ST_ID: begin
        if (w_is_illegal) begin
          w_next = ST_ERR;
        end else if (w_is_jump) begin
          w_pc_write = 1'b1;
          w_pc_src   = PC_SRC_JUMP;
          w_reg_wr   = w_is_link;
          w_link_wr  = w_is_link;
          w_retire   = 1'b1;
          w_next     = ST_IF;
        end else begin
          w_next = ST_EX;
        end
      end
      ST_EX: begin
        if (w_is_branch) begin
          if (bus.alu_zero) begin
            w_pc_write = 1'b1;
            w_pc_src   = PC_SRC_BRANCH;
          end
          w_retire = 1'b1;
          w_next   = ST_IF;
        end else if (w_is_load || w_is_store) begin
          w_next = ST_MEM;
        end else begin
          w_next = ST_WB;
        end
      end
      ST_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = w_is_store;
        if (bus.dmem_ready) begin
          if (w_is_store) begin
            w_retire = 1'b1;
            w_next   = ST_IF;
          end else begin
            w_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        w_reg_wr = 1'b1;
        w_retire = 1'b1;
        w_next   = ST_IF;
      end
      ST_ERR:  w_next = ST_ERR;
      default: w_next = ST_IF;
    endcase
  end

  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IF;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_ID && w_is_illegal) r_illegal <= 1'b1;
      if (w_retire) r_count <= r_count + CNT_W'(1);
    end
  end

  // Strobes are qualified by reset_n so a reset mid-access kills them in the
  // same cycle rather than exposing the IF decode while the state is held.
  assign bus.imem_req    = reset_n & w_imem_req;
  assign bus.ir_write    = reset_n & w_ir_write;
  assign bus.pc_write    = reset_n & w_pc_write;
  assign bus.pc_src      = reset_n ? w_pc_src : PC_SRC_SEQ;
  assign bus.reg_wr      = reset_n & w_reg_wr;
  assign bus.link_wr     = reset_n & w_link_wr;
  assign bus.dmem_req    = reset_n & w_dmem_req;
  assign bus.dmem_we     = reset_n & w_dmem_we;
  assign bus.instr_done  = reset_n & w_retire;
  assign bus.state       = r_state;
  assign bus.illegal     = r_illegal;
  assign bus.instr_count = r_count;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: walks each instruction class phase by
// phase with hand-computed strobe vectors, then illegal, wrap and reset cases.
module tb_multicycle_sequencer;

  localparam int CNT_W = 4;

  // Strobe vector order: imem_req ir_write pc_write pc_src[1:0] reg_wr link_wr
  // dmem_req dmem_we instr_done
  localparam logic [9:0] S_NONE    = 10'b0000000000;
  localparam logic [9:0] S_IF_WAIT = 10'b1000000000;
  localparam logic [9:0] S_IF_RDY  = 10'b1110000000;
  localparam logic [9:0] S_J_ID    = 10'b0011000001;
  localparam logic [9:0] S_JAL_ID  = 10'b0011011001;
  localparam logic [9:0] S_BEQ_T   = 10'b0010100001;
  localparam logic [9:0] S_BEQ_NT  = 10'b0000000001;
  localparam logic [9:0] S_LW_MEM  = 10'b0000000100;
  localparam logic [9:0] S_SW_WAIT = 10'b0000000110;
  localparam logic [9:0] S_SW_DONE = 10'b0000000111;
  localparam logic [9:0] S_WB      = 10'b0000010001;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  int               n_vec = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  multicycle_sequencer_if #(.CNT_W(CNT_W)) bus ();

  multicycle_sequencer #(.CNT_W(CNT_W)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  wire [9:0] w_strb = {bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src,
                       bus.reg_wr, bus.link_wr, bus.dmem_req, bus.dmem_we,
                       bus.instr_done};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cycle(input string tag, input int st, input logic [9:0] strb);
    #1;
    check({tag, ".state"}, 32'(bus.state), 32'(st));
    check({tag, ".strb"}, 32'(w_strb), 32'(strb));
  endtask

  task automatic set_ir(input logic [1:0] t, input logic [4:0] op);
    bus.instr_type = t;
    bus.opcode     = op;
  endtask

  task automatic retire_check(input string tag);
    exp_cnt = exp_cnt + 1'b1;
    check({tag, ".cnt"}, 32'(bus.instr_count), 32'(exp_cnt));
  endtask

  task automatic run_alu(input string tag, input logic [1:0] t, input logic [4:0] op);
    set_ir(t, op);
    chk_cycle({tag, "_if"}, 0, S_IF_RDY); tick();
    chk_cycle({tag, "_id"}, 1, S_NONE);   tick();
    chk_cycle({tag, "_ex"}, 2, S_NONE);   tick();
    chk_cycle({tag, "_wb"}, 4, S_WB);     tick();
    retire_check(tag);
  endtask

  task automatic run_jump(input string tag, input logic link);
    set_ir(2'b10, link ? 5'd1 : 5'd0);
    chk_cycle({tag, "_if"}, 0, S_IF_RDY); tick();
    chk_cycle({tag, "_id"}, 1, link ? S_JAL_ID : S_J_ID); tick();
    check({tag, ".next"}, 32'(bus.state), 32'd0);
    retire_check(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_ir(2'b00, 5'd1);
    bus.alu_zero   = 1'b0;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;

    // Reset: state IF, counters clear, strobes suppressed despite imem_ready.
    tick(); tick();
    chk_cycle("rst", 0, S_NONE);
    check("rst.cnt", 32'(bus.instr_count), 32'd0);
    check("rst.illegal", 32'(bus.illegal), 32'd0);
    tick();
    reset_n = 1'b1;

    run_alu("add", 2'b00, 5'd1);

    // LW with dmem_ready high outside MEM (ignored), then two wait cycles.
    set_ir(2'b01, 5'd2);
    chk_cycle("lw_if", 0, S_IF_RDY);  tick();
    chk_cycle("lw_id", 1, S_NONE);    tick();
    chk_cycle("lw_ex", 2, S_NONE);    tick();
    bus.dmem_ready = 1'b0;
    chk_cycle("lw_mem0", 3, S_LW_MEM); tick();
    chk_cycle("lw_mem1", 3, S_LW_MEM); tick();
    bus.dmem_ready = 1'b1;
    chk_cycle("lw_mem2", 3, S_LW_MEM); tick();
    chk_cycle("lw_wb", 4, S_WB);       tick();
    retire_check("lw");

    bus.alu_zero = 1'b1;
    set_ir(2'b01, 5'd4);
    chk_cycle("beq_t_if", 0, S_IF_RDY); tick();
    chk_cycle("beq_t_id", 1, S_NONE);   tick();
    chk_cycle("beq_t_ex", 2, S_BEQ_T);  tick();
    retire_check("beq_t");

    bus.alu_zero = 1'b0;
    chk_cycle("beq_n_if", 0, S_IF_RDY); tick();
    chk_cycle("beq_n_id", 1, S_NONE);   tick();
    chk_cycle("beq_n_ex", 2, S_BEQ_NT); tick();
    retire_check("beq_n");

    run_jump("jal", 1'b1);

    // J after one instruction-memory wait cycle.
    set_ir(2'b10, 5'd0);
    bus.imem_ready = 1'b0;
    chk_cycle("j_wait", 0, S_IF_WAIT); tick();
    bus.imem_ready = 1'b1;
    run_jump("j", 1'b0);

    bus.alu_zero = 1'b1;
    run_alu("cmp", 2'b00, 5'd3);
    run_alu("sll", 2'b11, 5'd0);
    run_alu("andi", 2'b01, 5'd0);
    bus.alu_zero = 1'b0;

    set_ir(2'b01, 5'd3);
    chk_cycle("sw_if", 0, S_IF_RDY);   tick();
    chk_cycle("sw_id", 1, S_NONE);     tick();
    chk_cycle("sw_ex", 2, S_NONE);     tick();
    chk_cycle("sw_mem", 3, S_SW_DONE); tick();
    retire_check("sw");

    // Ten retires so far; six more J reach 16 and wrap the 4-bit counter.
    for (int i = 0; i < 5; i++) run_jump("fill", 1'b0);
    check("pre_wrap.cnt", 32'(bus.instr_count), 32'd15);
    run_jump("wrap", 1'b0);
    check("wrap.zero", 32'(bus.instr_count), 32'd0);
    run_jump("post_wrap", 1'b0);

    // Reset asserted while SW waits in MEM: strobes and state drop at once.
    set_ir(2'b01, 5'd3);
    bus.dmem_ready = 1'b0;
    chk_cycle("swr_if", 0, S_IF_RDY);   tick();
    chk_cycle("swr_id", 1, S_NONE);     tick();
    chk_cycle("swr_ex", 2, S_NONE);     tick();
    chk_cycle("swr_mem", 3, S_SW_WAIT);
    reset_n = 1'b0;
    chk_cycle("swr_rst", 0, S_NONE);
    check("swr_rst.cnt", 32'(bus.instr_count), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    bus.dmem_ready = 1'b1;
    exp_cnt = '0;
    chk_cycle("swr_release", 0, S_IF_RDY);

    // Illegal J opcode 5: ERR is terminal until reset, whatever the inputs.
    set_ir(2'b10, 5'd5);
    tick();
    chk_cycle("ill_id", 1, S_NONE);
    check("ill_id.illegal", 32'(bus.illegal), 32'd0);
    tick();
    for (int i = 0; i < 12; i++) begin
      set_ir(2'b10, 5'd1);
      bus.imem_ready = i[0];
      bus.alu_zero   = ~i[0];
      chk_cycle("ill_err", 5, S_NONE);
      check("ill_err.illegal", 32'(bus.illegal), 32'd1);
      tick();
    end
    check("ill_err.cnt", 32'(bus.instr_count), 32'd0);
    reset_n = 1'b0;
    chk_cycle("ill_rst", 0, S_NONE);
    check("ill_rst.illegal", 32'(bus.illegal), 32'd0);
    tick();
    reset_n = 1'b1;
    bus.imem_ready = 1'b1;
    run_jump("recover", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
